even_fwd_hazard_unit: RTL and testbench

Consumer end of the even-pipe forwarding bus: takes the seven packed stage words and the write-back bus from the even pipe and resolves operands for the next instruction at issue. A per-register latency scoreboard stalls issue while a producer's result is not yet computed. Otherwise it forwards the youngest matching in-flight result, then the write-back bus, then register-file data. It sits between register-file read and even-pipe issue.

---
 rtl/even_fwd_hazard_unit.sv | 168 ++++++++++++++++
 tb/tb_even_fwd_hazard_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/even_fwd_hazard_unit.sv
// Even-pipe operand resolver: latency scoreboard stall plus
// youngest-first forwarding from stage words, write-back, then RF.
module even_fwd_hazard_unit #(
    parameter int NUM_REGS = 128,
    parameter int CNT_W    = 4,
    parameter int STAGES   = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_valid,
    input  logic [6:0]   issue_ra_addr,
    input  logic [6:0]   issue_rb_addr,
    input  logic [6:0]   issue_rc_addr,
    input  logic         issue_ra_use,
    input  logic         issue_rb_use,
    input  logic         issue_rc_use,
    input  logic [6:0]   issue_reg_dst,
    input  logic [3:0]   issue_latency,
    input  logic         issue_reg_wr,
    input  logic [127:0] rf_ra_data,
    input  logic [127:0] rf_rb_data,
    input  logic [127:0] rf_rc_data,
    input  logic [142:0] packed_1stage,
    input  logic [142:0] packed_2stage,
    input  logic [142:0] packed_3stage,
    input  logic [142:0] packed_4stage,
    input  logic [142:0] packed_5stage,
    input  logic [142:0] packed_6stage,
    input  logic [142:0] packed_7stage,
    input  logic [6:0]   WB_reg_write_addr,
    input  logic [127:0] WB_reg_write_data,
    input  logic         WB_reg_write_en,
    output logic         stall,
    output logic         issue_fire,
    output logic [127:0] ra_data,
    output logic [127:0] rb_data,
    output logic [127:0] rc_data,
    output logic [31:0]  stall_cycles
);

    localparam int AW = 7;
    localparam int DW = 128;
    localparam int PW = 143;
    localparam int NSRC = 3;

    localparam int RES_LO = 3;
    localparam int RES_HI = 130;
    localparam int DST_LO = 131;
    localparam int DST_HI = 137;
    localparam int LAT_LO = 138;
    localparam int LAT_HI = 141;
    localparam int WR_BIT = 142;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [PW-1:0]    stg      [STAGES];
    logic [DW-1:0]    stg_res  [STAGES];
    logic [AW-1:0]    stg_dst  [STAGES];
    logic [CNT_W-1:0] stg_lat  [STAGES];
    logic             stg_wr   [STAGES];
    logic             stg_done [STAGES];

    logic [AW-1:0]    src_addr [NSRC];
    logic             src_use  [NSRC];
    logic [DW-1:0]    src_rf   [NSRC];
    logic [DW-1:0]    src_out  [NSRC];
    logic             src_busy [NSRC];

    logic [CNT_W-1:0] sb_cnt [NUM_REGS];
    logic [CNT_W-1:0] issue_lat_eff;
    logic [CNT_W-1:0] sb_load_val;
    logic             sb_load;
    logic             any_busy;
    logic             unused_unit;

    assign stg[0] = packed_1stage;
    assign stg[1] = packed_2stage;
    assign stg[2] = packed_3stage;
    assign stg[3] = packed_4stage;
    assign stg[4] = packed_5stage;
    assign stg[5] = packed_6stage;
    assign stg[6] = packed_7stage;

    assign src_addr[0] = issue_ra_addr;
    assign src_addr[1] = issue_rb_addr;
    assign src_addr[2] = issue_rc_addr;
    assign src_use[0]  = issue_ra_use;
    assign src_use[1]  = issue_rb_use;
    assign src_use[2]  = issue_rc_use;
    assign src_rf[0]   = rf_ra_data;
    assign src_rf[1]   = rf_rb_data;
    assign src_rf[2]   = rf_rc_data;

    // Split stage words into fields; a result is usable in stage k once latency <= k
    always_comb begin
        unused_unit = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            stg_res[k]  = stg[k][RES_HI:RES_LO];
            stg_dst[k]  = stg[k][DST_HI:DST_LO];
            stg_lat[k]  = stg[k][LAT_HI:LAT_LO];
            stg_wr[k]   = stg[k][WR_BIT];
            unused_unit = unused_unit ^ (^stg[k][2:0]);
            if (stg_lat[k] == '0) begin
                stg_done[k] = 1'b1;
            end else begin
                stg_done[k] = stg_lat[k] <= CNT_W'(k + 1);
            end
        end
    end

    // Per-source operand mux: RF, overridden by WB, overridden by oldest..youngest stage
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            src_out[s] = src_rf[s];
            if (WB_reg_write_en && WB_reg_write_addr == src_addr[s]) begin
                src_out[s] = WB_reg_write_data;
            end
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (stg_wr[k] && stg_done[k] && stg_dst[k] == src_addr[s]) begin
                    src_out[s] = stg_res[k];
                end
            end
        end
    end

    assign ra_data = src_out[0];
    assign rb_data = src_out[1];
    assign rc_data = src_out[2];

    // Hazard check: any used source whose producer has not finished
    always_comb begin
        any_busy = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            src_busy[s] = src_use[s] && (sb_cnt[src_addr[s]] != '0);
            any_busy    = any_busy | src_busy[s];
        end
    end

    assign stall      = ~rst & issue_valid & any_busy;
    assign issue_fire = ~rst & issue_valid & ~any_busy;

    assign issue_lat_eff = (issue_latency == '0) ? CNT_ONE : issue_latency;
    assign sb_load_val   = issue_lat_eff - CNT_ONE;
    assign sb_load       = issue_fire & issue_reg_wr;

    // Scoreboard countdown; a firing writer reloads its destination count
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst) begin
                sb_cnt[r] <= '0;
            end else if (sb_load && issue_reg_dst == AW'(r)) begin
                sb_cnt[r] <= sb_load_val;
            end else if (sb_cnt[r] != '0) begin
                sb_cnt[r] <= sb_cnt[r] - CNT_ONE;
            end
        end
    end

    // Saturating count of cycles a valid candidate was held
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_even_fwd_hazard_unit.sv
// Bench for even_fwd_hazard_unit: vector table, corner sequences,
// and random stimulus against a timestamp-based reference model.
module tb_even_fwd_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         issue_valid;
    logic [6:0]   issue_ra_addr, issue_rb_addr, issue_rc_addr;
    logic         issue_ra_use, issue_rb_use, issue_rc_use;
    logic [6:0]   issue_reg_dst;
    logic [3:0]   issue_latency;
    logic         issue_reg_wr;
    logic [127:0] rf_ra_data, rf_rb_data, rf_rc_data;
    logic [142:0] pw [7];
    logic [6:0]   WB_reg_write_addr;
    logic [127:0] WB_reg_write_data;
    logic         WB_reg_write_en;
    logic         stall, issue_fire;
    logic [127:0] ra_data, rb_data, rc_data;
    logic [31:0]  stall_cycles;

    even_fwd_hazard_unit dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_ra_addr(issue_ra_addr), .issue_rb_addr(issue_rb_addr),
        .issue_rc_addr(issue_rc_addr), .issue_ra_use(issue_ra_use),
        .issue_rb_use(issue_rb_use), .issue_rc_use(issue_rc_use),
        .issue_reg_dst(issue_reg_dst), .issue_latency(issue_latency),
        .issue_reg_wr(issue_reg_wr), .rf_ra_data(rf_ra_data),
        .rf_rb_data(rf_rb_data), .rf_rc_data(rf_rc_data),
        .packed_1stage(pw[0]), .packed_2stage(pw[1]), .packed_3stage(pw[2]),
        .packed_4stage(pw[3]), .packed_5stage(pw[4]), .packed_6stage(pw[5]),
        .packed_7stage(pw[6]), .WB_reg_write_addr(WB_reg_write_addr),
        .WB_reg_write_data(WB_reg_write_data), .WB_reg_write_en(WB_reg_write_en),
        .stall(stall), .issue_fire(issue_fire), .ra_data(ra_data),
        .rb_data(rb_data), .rc_data(rc_data), .stall_cycles(stall_cycles)
    );

    localparam logic [127:0] AA   = {16{8'hAA}};
    localparam logic [127:0] FIVE = {16{8'h55}};
    localparam logic [127:0] V1   = {4{32'h1111_0001}};
    localparam logic [127:0] V2   = {4{32'h2222_0002}};
    localparam logic [127:0] RF_A = {4{32'hF00D_000A}};
    localparam logic [127:0] RF_B = {4{32'hF00D_000B}};
    localparam logic [127:0] RF_C = {4{32'hF00D_000C}};

    int tests = 0;
    int fails = 0;

    // Reference model: a register is ready from an absolute cycle number
    longint      cyc = 0;
    longint      ready [128];
    logic [31:0] sc_m = 0;

    typedef struct {
        string        nm;
        int           s1;
        logic [142:0] w1;
        int           s2;
        logic [142:0] w2;
        logic         wbe;
        logic [6:0]   wba;
        logic [127:0] wbd;
        logic [6:0]   a;
        logic [127:0] exp;
    } vec_t;

    vec_t tv [10];

    function automatic logic [142:0] pk(logic [6:0] d, logic [3:0] l,
                                        logic w, logic [127:0] r);
        return {w, l, d, r, 3'b101};
    endfunction

    function automatic vec_t mk(string nm, int s1, logic [142:0] w1,
                                int s2, logic [142:0] w2, logic wbe,
                                logic [6:0] wba, logic [127:0] wbd,
                                logic [6:0] a, logic [127:0] exp);
        vec_t v;
        v.nm = nm; v.s1 = s1; v.w1 = w1; v.s2 = s2; v.w2 = w2;
        v.wbe = wbe; v.wba = wba; v.wbd = wbd; v.a = a; v.exp = exp;
        return v;
    endfunction

    function automatic logic [127:0] fwd_ref(logic [6:0] a, logic [127:0] rf);
        int le;
        for (int k = 0; k < 7; k++) begin
            le = (pw[k][141:138] == 0) ? 1 : int'(pw[k][141:138]);
            if (pw[k][142] && pw[k][137:131] == a && le <= k + 1)
                return pw[k][130:3];
        end
        if (WB_reg_write_en && WB_reg_write_addr == a)
            return WB_reg_write_data;
        return rf;
    endfunction

    function automatic bit pend(logic [6:0] a);
        return cyc < ready[a];
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        issue_valid = 0;
        issue_ra_addr = 0; issue_rb_addr = 0; issue_rc_addr = 0;
        issue_ra_use = 0; issue_rb_use = 0; issue_rc_use = 0;
        issue_reg_dst = 0; issue_latency = 0; issue_reg_wr = 0;
        rf_ra_data = RF_A; rf_rb_data = RF_B; rf_rc_data = RF_C;
        for (int k = 0; k < 7; k++) pw[k] = '0;
        WB_reg_write_addr = 0; WB_reg_write_data = 0; WB_reg_write_en = 0;
    endtask

    // Check all outputs against the model, then advance one clock
    task automatic tick();
        logic st, fi;
        longint le;
        #1;
        st = !rst && issue_valid &&
             ((issue_ra_use && pend(issue_ra_addr)) ||
              (issue_rb_use && pend(issue_rb_addr)) ||
              (issue_rc_use && pend(issue_rc_addr)));
        fi = !rst && issue_valid && !st;
        chk("m_stall", {127'd0, stall}, {127'd0, st});
        chk("m_fire", {127'd0, issue_fire}, {127'd0, fi});
        chk("m_ra", ra_data, fwd_ref(issue_ra_addr, rf_ra_data));
        chk("m_rb", rb_data, fwd_ref(issue_rb_addr, rf_rb_data));
        chk("m_rc", rc_data, fwd_ref(issue_rc_addr, rf_rc_data));
        chk("m_stall_cycles", {96'd0, stall_cycles}, {96'd0, sc_m});
        @(posedge clk);
        if (rst) begin
            foreach (ready[i]) ready[i] = 0;
            sc_m = 0;
        end else begin
            le = (issue_latency == 0) ? 1 : longint'(issue_latency);
            if (fi && issue_reg_wr) ready[issue_reg_dst] = cyc + le;
            if (st && sc_m != 32'hFFFF_FFFF) sc_m = sc_m + 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        foreach (ready[i]) ready[i] = 0;
        clr();
        rst = 1;
        @(negedge clk);
        tick();
        tick();
        rst = 0;

        // Reset state
        issue_valid = 1; issue_ra_addr = 5; issue_ra_use = 1;
        #1;
        chk("rst_stall_cycles", {96'd0, stall_cycles}, 128'd0);
        chk("rst_no_stall", {127'd0, stall}, 128'd0);
        tick();

        // Combinational forwarding table
        tv[0] = mk("youngest", 3, pk(9, 3, 1, AA), 6, pk(9, 6, 1, FIVE), 0, 0, 0, 9, AA);
        tv[1] = mk("lat_skip", 3, pk(9, 4, 1, AA), 6, pk(9, 2, 1, FIVE), 0, 0, 0, 9, FIVE);
        tv[2] = mk("wb_hit", 0, 0, 0, 0, 1, 12, 128'h1234, 12, 128'h1234);
        tv[3] = mk("rf_fall", 0, 0, 0, 0, 0, 12, 128'h1234, 12, RF_A);
        tv[4] = mk("lat0_s1", 1, pk(3, 0, 1, V1), 0, 0, 0, 0, 0, 3, V1);
        tv[5] = mk("skip_to_wb", 7, pk(4, 15, 1, AA), 0, 0, 1, 4, V2, 4, V2);
        tv[6] = mk("regwr0", 2, pk(5, 1, 0, AA), 0, 0, 0, 0, 0, 5, RF_A);
        tv[7] = mk("stage_over_wb", 5, pk(6, 5, 1, FIVE), 0, 0, 1, 6, V2, 6, FIVE);
        tv[8] = mk("addr_miss", 1, pk(1, 1, 1, AA), 0, 0, 0, 0, 0, 0, RF_A);
        tv[9] = mk("s7_hit", 7, pk(10, 7, 1, V1), 4, pk(10, 5, 1, AA), 0, 0, 0, 10, V1);
        for (int i = 0; i < 10; i++) begin
            clr();
            if (tv[i].s1 > 0) pw[tv[i].s1 - 1] = tv[i].w1;
            if (tv[i].s2 > 0) pw[tv[i].s2 - 1] = tv[i].w2;
            WB_reg_write_en = tv[i].wbe;
            WB_reg_write_addr = tv[i].wba;
            WB_reg_write_data = tv[i].wbd;
            issue_ra_addr = tv[i].a;
            #1;
            chk(tv[i].nm, ra_data, tv[i].exp);
            tick();
        end

        // r5 latency 2: stall one cycle, then forward from stage 2
        clr(); issue_valid = 1; issue_reg_dst = 5; issue_latency = 2; issue_reg_wr = 1;
        #1; chk("a_issue_fire", {127'd0, issue_fire}, 128'd1);
        tick();
        clr(); issue_valid = 1; issue_ra_addr = 5; issue_ra_use = 1;
        #1; chk("a_stall", {127'd0, stall}, 128'd1);
        chk("a_no_fire", {127'd0, issue_fire}, 128'd0);
        tick();
        pw[1] = pk(5, 2, 1, V1);
        #1; chk("a_released", {127'd0, stall}, 128'd0);
        chk("a_fwd_s2", ra_data, V1);
        chk("a_stall_cycles", {96'd0, stall_cycles}, 128'd1);
        tick();

        // Unused pending source never stalls
        clr(); issue_valid = 1; issue_reg_dst = 7; issue_latency = 5; issue_reg_wr = 1;
        tick();
        clr(); issue_valid = 1; issue_rc_addr = 7; issue_rc_use = 1;
        #1; chk("b_used_stall", {127'd0, stall}, 128'd1);
        issue_rc_use = 0;
        #1; chk("b_unused_nostall", {127'd0, stall}, 128'd0);
        chk("b_unused_fire", {127'd0, issue_fire}, 128'd1);
        tick();

        // Latency 0 behaves as 1
        clr(); issue_valid = 1; issue_reg_dst = 3; issue_latency = 0; issue_reg_wr = 1;
        tick();
        clr(); issue_valid = 1; issue_ra_addr = 3; issue_ra_use = 1;
        pw[0] = pk(3, 0, 1, V2);
        #1; chk("c_lat0_nostall", {127'd0, stall}, 128'd0);
        chk("c_lat0_fwd", ra_data, V2);
        tick();

        // Source equal to own destination sees the older pending write
        clr(); issue_valid = 1; issue_reg_dst = 9; issue_latency = 4; issue_reg_wr = 1;
        tick();
        clr(); issue_valid = 1; issue_ra_addr = 9; issue_ra_use = 1;
        issue_reg_dst = 9; issue_latency = 1; issue_reg_wr = 1;
        #1; chk("e_self_dst_stall", {127'd0, stall}, 128'd1);
        tick();

        // Reset mid-flight clears scoreboard and stall counter
        clr(); issue_valid = 1; issue_reg_dst = 20; issue_latency = 6; issue_reg_wr = 1;
        tick();
        clr(); issue_valid = 1; issue_ra_addr = 20; issue_ra_use = 1;
        rst = 1;
        #1; chk("d_rst_stall", {127'd0, stall}, 128'd0);
        chk("d_rst_fire", {127'd0, issue_fire}, 128'd0);
        tick();
        rst = 0;
        #1; chk("d_cleared_stall", {127'd0, stall}, 128'd0);
        chk("d_cleared_cycles", {96'd0, stall_cycles}, 128'd0);
        chk("d_cleared_fire", {127'd0, issue_fire}, 128'd1);
        tick();

        // Random traffic over a small register window
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_ra_addr = 7'($urandom_range(0, 7));
            issue_rb_addr = 7'($urandom_range(0, 7));
            issue_rc_addr = 7'($urandom_range(0, 7));
            issue_ra_use = 1'($urandom_range(0, 1));
            issue_rb_use = 1'($urandom_range(0, 1));
            issue_rc_use = 1'($urandom_range(0, 1));
            issue_reg_dst = 7'($urandom_range(0, 7));
            issue_latency = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
            issue_reg_wr = 1'($urandom_range(0, 1));
            rf_ra_data = {$urandom, $urandom, $urandom, $urandom};
            rf_rb_data = {$urandom, $urandom, $urandom, $urandom};
            rf_rc_data = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 7; k++)
                pw[k] = pk(7'($urandom_range(0, 7)), 4'($urandom_range(0, 9)),
                           1'($urandom_range(0, 1)),
                           {$urandom, $urandom, $urandom, $urandom});
            WB_reg_write_en = 1'($urandom_range(0, 1));
            WB_reg_write_addr = 7'($urandom_range(0, 7));
            WB_reg_write_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
